// File: rtl/data_sram_responder_if.sv
// Request/response bundle between the execute-stage data port and the data SRAM responder.
interface data_sram_responder_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        rdata_valid;

   modport master (
      output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
      input  data_sram_rdata, rdata_valid
   );

   modport slave (
      input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
      output data_sram_rdata, rdata_valid
   );
endinterface

// File: rtl/data_sram_responder.sv
// Byte-masked word SRAM model with a fixed LAT-cycle response pipeline, write-first
// responses, an out-of-range sticky flag and wrapping request counters.
module data_sram_responder #(
   parameter int unsigned AW  = 12,
   parameter int unsigned LAT = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   data_sram_responder_if.slave  bus,
   output logic                  addr_err,
   output logic [15:0]           wr_count,
   output logic [15:0]           rd_count
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic          in_range;
   logic          is_wr;
   logic          is_rd;
   logic [31:0]   resp_word;

   logic          pipe_req  [LAT];
   logic          pipe_rd   [LAT];
   logic [31:0]   pipe_word [LAT];

   assign idx      = bus.data_sram_addr[AW+1:2];
   assign in_range = (bus.data_sram_addr[31:AW+2] == '0);
   assign is_wr    = bus.data_sram_en && (bus.data_sram_wen != '0);
   assign is_rd    = bus.data_sram_en && (bus.data_sram_wen == '0);

   // Merged post-write word; for reads wen is zero so this is the stored word.
   always_comb begin
      resp_word = '0;
      if (in_range) begin
         resp_word = mem[idx];
         for (int unsigned i = 0; i < 4; i++) begin
            if (bus.data_sram_wen[i])
               resp_word[8*i +: 8] = bus.data_sram_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && is_wr && in_range) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (bus.data_sram_wen[i])
               mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
         end
      end
   end

   // Stage words load only behind a live request, so the last stage doubles as the holding rdata register.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned s = 0; s < LAT; s++) begin
            pipe_req[s]  <= 1'b0;
            pipe_rd[s]   <= 1'b0;
            pipe_word[s] <= '0;
         end
         addr_err <= 1'b0;
         wr_count <= '0;
         rd_count <= '0;
      end else begin
         pipe_req[0] <= bus.data_sram_en;
         pipe_rd[0]  <= is_rd;
         if (bus.data_sram_en)
            pipe_word[0] <= resp_word;
         for (int unsigned s = 1; s < LAT; s++) begin
            pipe_req[s] <= pipe_req[s-1];
            pipe_rd[s]  <= pipe_rd[s-1];
            if (pipe_req[s-1])
               pipe_word[s] <= pipe_word[s-1];
         end
         if (bus.data_sram_en && !in_range)
            addr_err <= 1'b1;
         if (is_wr && in_range)
            wr_count <= wr_count + 16'd1;
         if (is_rd)
            rd_count <= rd_count + 16'd1;
      end
   end

   assign bus.data_sram_rdata = pipe_word[LAT-1];
   assign bus.rdata_valid     = pipe_rd[LAT-1];

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench driving four responders (LAT=1..4) with identical request streams.
module tb_data_sram_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic [31:0] rdata_w [4];
   logic        vld_w   [4];
   logic        err_w   [4];
   logic [15:0] wrc_w   [4];
   logic [15:0] rdc_w   [4];

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   bit chk_on = 1'b1;

   logic        hv [8];
   logic [31:0] hd [8];

   always #5 clk = ~clk;

   data_sram_responder_if bus0 ();
   data_sram_responder_if bus1 ();
   data_sram_responder_if bus2 ();
   data_sram_responder_if bus3 ();

   assign bus0.data_sram_en = en;  assign bus0.data_sram_wen = wen;
   assign bus0.data_sram_addr = addr;  assign bus0.data_sram_wdata = wdata;
   assign bus1.data_sram_en = en;  assign bus1.data_sram_wen = wen;
   assign bus1.data_sram_addr = addr;  assign bus1.data_sram_wdata = wdata;
   assign bus2.data_sram_en = en;  assign bus2.data_sram_wen = wen;
   assign bus2.data_sram_addr = addr;  assign bus2.data_sram_wdata = wdata;
   assign bus3.data_sram_en = en;  assign bus3.data_sram_wen = wen;
   assign bus3.data_sram_addr = addr;  assign bus3.data_sram_wdata = wdata;

   assign rdata_w[0] = bus0.data_sram_rdata;  assign vld_w[0] = bus0.rdata_valid;
   assign rdata_w[1] = bus1.data_sram_rdata;  assign vld_w[1] = bus1.rdata_valid;
   assign rdata_w[2] = bus2.data_sram_rdata;  assign vld_w[2] = bus2.rdata_valid;
   assign rdata_w[3] = bus3.data_sram_rdata;  assign vld_w[3] = bus3.rdata_valid;

   data_sram_responder #(.AW(12), .LAT(1)) u_lat1 (
      .clk(clk), .reset(reset), .bus(bus0),
      .addr_err(err_w[0]), .wr_count(wrc_w[0]), .rd_count(rdc_w[0]));
   data_sram_responder #(.AW(12), .LAT(2)) u_lat2 (
      .clk(clk), .reset(reset), .bus(bus1),
      .addr_err(err_w[1]), .wr_count(wrc_w[1]), .rd_count(rdc_w[1]));
   data_sram_responder #(.AW(12), .LAT(3)) u_lat3 (
      .clk(clk), .reset(reset), .bus(bus2),
      .addr_err(err_w[2]), .wr_count(wrc_w[2]), .rd_count(rdc_w[2]));
   data_sram_responder #(.AW(12), .LAT(4)) u_lat4 (
      .clk(clk), .reset(reset), .bus(bus3),
      .addr_err(err_w[3]), .wr_count(wrc_w[3]), .rd_count(rdc_w[3]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, want);
   endtask

   // One clock: drive a request, note the expected read response, then compare every
   // instance against the request issued exactly LAT cycles earlier.
   task automatic step(input logic rst_i, input logic en_i, input logic [3:0] wen_i,
                       input logic [31:0] a_i, input logic [31:0] d_i, input logic [31:0] rexp);
      int p;
      reset = rst_i; en = en_i; wen = wen_i; addr = a_i; wdata = d_i;
      @(posedge clk);
      if (rst_i)
         for (int i = 0; i < 8; i++) hv[i] = 1'b0;
      hv[cyc % 8] = en_i && !rst_i && (wen_i == 4'h0);
      hd[cyc % 8] = rexp;
      cyc++;
      #1;
      if (chk_on) begin
         for (int d = 0; d < 4; d++) begin
            p = cyc - (d + 1);
            if (p >= 0) begin
               check($sformatf("rdata_valid L%0d c%0d", d + 1, cyc), 32'(vld_w[d]), 32'(hv[p % 8]));
               if (hv[p % 8])
                  check($sformatf("rdata L%0d c%0d", d + 1, cyc), rdata_w[d], hd[p % 8]);
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
      step(1'b0, 1'b1, m, a, d, 32'h0);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] want);
      step(1'b0, 1'b1, 4'h0, a, 32'h0, want);
   endtask

   task automatic check_state(input string tag, input logic err, input logic [15:0] wc,
                              input logic [15:0] rc);
      for (int d = 0; d < 4; d++) begin
         check($sformatf("%s addr_err L%0d", tag, d + 1), 32'(err_w[d]), 32'(err));
         check($sformatf("%s wr_count L%0d", tag, d + 1), 32'(wrc_w[d]), 32'(wc));
         check($sformatf("%s rd_count L%0d", tag, d + 1), 32'(rdc_w[d]), 32'(rc));
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin hv[i] = 1'b0; hd[i] = '0; end
      step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
      step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
      for (int d = 0; d < 4; d++) begin
         check($sformatf("reset rdata L%0d", d + 1), rdata_w[d], 32'h0);
         check($sformatf("reset valid L%0d", d + 1), 32'(vld_w[d]), 32'h0);
      end
      check_state("reset", 1'b0, 16'd0, 16'd0);

      // Byte-masked write merge
      wr(32'h10, 4'hF, 32'hAABBCCDD);
      wr(32'h11, 4'b0010, 32'h0000_1100);
      rd(32'h13, 32'hAABB11DD);
      check_state("bytemask", 1'b0, 16'd2, 16'd1);
      idle(5);

      // Latency sweep: back-to-back writes then reads
      for (int i = 0; i < 4; i++) wr(32'h100 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i));
      for (int i = 0; i < 4; i++) rd(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      idle(5);

      // Read-after-write; the write itself returns the merged word on rdata
      wr(32'h40, 4'hF, 32'h1234_5678);
      check("write-first rdata L1", rdata_w[0], 32'h1234_5678);
      check("write no valid L1", 32'(vld_w[0]), 32'h0);
      rd(32'h40, 32'h1234_5678);
      idle(5);

      // Out of range: 0x4000 would alias word 0 if the high bits were dropped
      wr(32'h0, 4'hF, 32'h0BAD_F00D);
      check_state("pre-oor", 1'b0, 16'd8, 16'd6);
      wr(32'h0000_4000, 4'hF, 32'hDEAD_BEEF);
      check_state("oor write", 1'b1, 16'd8, 16'd6);
      rd(32'h0000_4000, 32'h0);
      rd(32'h0, 32'h0BAD_F00D);
      idle(5);
      check_state("oor sticky", 1'b1, 16'd8, 16'd8);

      // Reset mid-flight: third read coincides with reset and is ignored
      rd(32'h10, 32'hAABB11DD);
      rd(32'h40, 32'h1234_5678);
      step(1'b1, 1'b1, 4'h0, 32'h100, 32'h0, 32'h0);
      for (int d = 0; d < 4; d++)
         check($sformatf("midreset rdata L%0d", d + 1), rdata_w[d], 32'h0);
      check_state("midreset", 1'b0, 16'd0, 16'd0);
      idle(5);
      rd(32'h40, 32'h1234_5678);
      idle(5);

      // Counter wrap
      chk_on = 1'b0;
      for (int i = 0; i < 65535; i++) wr(32'((i % 4096) * 4), 4'hF, 32'(i));
      check_state("wrap-1", 1'b0, 16'hFFFF, 16'd1);
      wr(32'(4095 * 4), 4'hF, 32'h0000_FFFF);
      check_state("wrap", 1'b0, 16'h0000, 16'd1);
      chk_on = 1'b1;
      rd(32'(4095 * 4), 32'h0000_FFFF);
      idle(5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
